// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry and pointer-width helper
package fifo_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 32;
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, synchronous write, combinational read
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/prog_fifo.sv
// prog_fifo: synchronous FIFO with programmable flags, FWFT/registered read and sticky errors
module prog_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d, rdata;
    logic             valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic             wr_ok, rd_ok;
    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );
    always_comb begin
        wr_ok    = wr && !full;
        rd_ok    = rd && !empty;
        wr_ptr_d = wr_ptr_q + PW'(wr_ok);
        rd_ptr_d = rd_ptr_q + PW'(rd_ok);
        count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
        dout_d   = rd_ok ? rdata : dout_q;
        valid_d  = rd_ok;
        ovf_d    = (wr && full) || (ovf_q && !clr_err);
        unf_d    = (rd && empty) || (unf_q && !clr_err);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end
    assign count        = count_q;
    assign empty        = count_q == '0;
    assign full         = count_q == CW'(DEPTH);
    assign almost_empty = count_q <= CW'(AE_THRESH);
    assign almost_full  = count_q >= CW'(AF_THRESH);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    // fall-through output is forced to zero while empty so stale RAM never shows
    assign valid        = (FWFT != 0) ? !empty : valid_q;
    assign data_out     = (FWFT != 0) ? (empty ? '0 : rdata) : dout_q;
endmodule

// File: tb/tb_prog_fifo.sv
// tb_prog_fifo: randomized and directed check of FWFT and registered-read builds against a queue model
module tb_prog_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] dout_a, dout_b;
    logic       valid_a, valid_b, empty_a, empty_b, full_a, full_b;
    logic       ae_a, ae_b, af_a, af_b, ovf_a, ovf_b, unf_a, unf_b;
    logic [5:0] count_a, count_b;
    int         vectors = 0, miscompares = 0;
    int         q[$];
    bit         m_ovf, m_unf, m_valid0;
    logic [7:0] m_dout0;

    always #5 clk = ~clk;

    prog_fifo #(.WIDTH(8), .DEPTH(32), .FWFT(1)) u_ff (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd), .clr_err(clr_err),
        .data_out(dout_a), .valid(valid_a), .empty(empty_a), .full(full_a),
        .almost_empty(ae_a), .almost_full(af_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a));

    prog_fifo #(.WIDTH(8), .DEPTH(32), .FWFT(0)) u_rg (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd), .clr_err(clr_err),
        .data_out(dout_b), .valid(valid_b), .empty(empty_b), .full(full_b),
        .almost_empty(ae_b), .almost_full(af_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic c, input logic rs, input logic [7:0] d);
        bit was_full, was_empty, wa, ra;
        wr = w; rd = r; clr_err = c; rst = rs; data_in = d;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_valid0 = 0; m_dout0 = '0;
        end else begin
            was_full  = q.size() == 32;
            was_empty = q.size() == 0;
            wa = w && !was_full;
            ra = r && !was_empty;
            m_valid0 = ra;
            if (ra) m_dout0 = 8'(q.pop_front());
            if (wa) q.push_back(int'(d));
            m_ovf = (w && was_full) || (m_ovf && !c);
            m_unf = (r && was_empty) || (m_unf && !c);
        end
        #1;
        chk("count_ff", 32'(count_a), q.size());
        chk("count_rg", 32'(count_b), q.size());
        chk("empty", 32'(empty_a), 32'(q.size() == 0));
        chk("full", 32'(full_a), 32'(q.size() == 32));
        chk("almost_empty", 32'(ae_a), 32'(q.size() <= 4));
        chk("almost_full", 32'(af_a), 32'(q.size() >= 28));
        chk("overflow", 32'(ovf_a), 32'(m_ovf));
        chk("underflow", 32'(unf_a), 32'(m_unf));
        chk("overflow_rg", 32'(ovf_b), 32'(m_ovf));
        chk("underflow_rg", 32'(unf_b), 32'(m_unf));
        chk("valid_ff", 32'(valid_a), 32'(q.size() != 0));
        chk("data_ff", 32'(dout_a), q.size() != 0 ? q[0] : 0);
        chk("valid_rg", 32'(valid_b), 32'(m_valid0));
        chk("data_rg", 32'(dout_b), 32'(m_dout0));
    endtask

    initial begin
        step(0, 0, 0, 1, 8'h00);
        for (int i = 1; i <= 32; i++) step(1, 0, 0, 0, 8'(i));
        step(1, 0, 0, 0, 8'hEE);
        step(1, 1, 0, 0, 8'hEF);
        for (int i = 0; i < 33; i++) step(0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        step(0, 1, 1, 0, 8'h00);
        step(1, 0, 1, 0, 8'h11);
        step(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 100; i++) step(1, 1, 0, 0, 8'($urandom));
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0, 8'($urandom));
        step(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'(i + 100));
        step(1, 1, 1, 1, 8'h77);
        step(1, 0, 0, 0, 8'h3C);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        step(1, 0, 0, 0, 8'hA5);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/prog_fifo.md
PROG_FIFO -- requirements
Module: prog_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 32, number of storage entries, SHALL be a power of two and >= 4.
REQ-003 Parameter AF_THRESH, default DEPTH-4, almost_full threshold in words, SHALL lie in 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 4, almost_empty threshold in words, SHALL lie in 0..DEPTH-1.
REQ-005 Parameter FWFT, default 1: 1 = first-word-fall-through, 0 = standard registered read.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 wr  input  1  write request.
REQ-010 data_in  input  WIDTH  write data, sampled when a write is accepted.
REQ-011 rd  input  1  read request / pop.
REQ-012 clr_err  input  1  clears the sticky error flags.
REQ-013 data_out  output  WIDTH  read data.
REQ-014 valid  output  1  data_out holds a valid word.
REQ-015 empty / full  output  1 each  occupancy flags.
REQ-016 almost_empty / almost_full  output  1 each  programmable flags.
REQ-017 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-018 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-019 A write SHALL be accepted iff wr=1 and full=0; accepted data is stored at the write pointer, which then advances by 1 mod DEPTH.
REQ-020 A read SHALL be accepted iff rd=1 and empty=0; the read pointer then advances by 1 mod DEPTH.
REQ-021 Simultaneous accepted read and write SHALL leave count unchanged; a write while full is dropped even if rd=1 in the same cycle.
REQ-022 count SHALL increment on accepted write only, decrement on accepted read only, and never leave 0..DEPTH.
REQ-023 empty = (count==0), full = (count==DEPTH), almost_empty = (count<=AE_THRESH), almost_full = (count>=AF_THRESH), all reflecting the registered count.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication of data.
REQ-025 FWFT=1: data_out SHALL show the oldest stored word whenever empty=0, valid = !empty, an accepted read presents the next word in the following cycle.
REQ-026 FWFT=0: data_out SHALL be registered, updated on the clock edge after the read is accepted (1-cycle latency), valid pulses high for exactly that one cycle; data_out holds its value otherwise.
REQ-027 overflow SHALL set on any cycle with wr=1 and full=1; underflow SHALL set on any cycle with rd=1 and empty=1; both remain set until clr_err=1 or rst=1.
REQ-028 If clr_err=1 and an error event occur in the same cycle, the flag SHALL end set (event wins).
REQ-029 Data order SHALL be strictly first-in first-out across any mix of reads, writes and wrap-arounds.

Reset
REQ-030 rst=1 SHALL dominate wr, rd and clr_err in the same cycle.
REQ-031 After reset: count=0, pointers=0, empty=1, almost_empty=1, full=0, almost_full=0, valid=0, data_out=0, overflow=0, underflow=0.
REQ-032 Storage contents SHALL NOT be reset; reset mid-operation discards all stored words.

Structure
REQ-033 Package fifo_pkg SHALL hold the default WIDTH/DEPTH constants and a pointer-width helper function.
REQ-034 Storage SHALL be a sub-module fifo_ram: simple dual-port, one synchronous write port, one read port.

Verification
REQ-035 Fill/drain: write 1..32 with DEPTH=32 -> full=1 after 32nd write, count=32; read 32 -> data 1..32 in order, empty=1.
REQ-036 Flags: DEPTH=32 defaults, write 28 words -> almost_full rises on 28th, almost_empty falls on 5th.
REQ-037 Errors: write when full -> overflow=1, count stays 32; read when empty -> underflow=1; clr_err pulse -> both 0.
REQ-038 Simultaneous: at count=16, wr=rd=1 for 100 cycles -> count stays 16, order preserved through pointer wrap.
REQ-039 Reset mid-operation: rst at count=10 -> next cycle count=0, empty=1, valid=0; next write/read returns the new word.
REQ-040 FWFT=0 build: write 0xA5 then rd -> valid=1 with data_out=0xA5 exactly one cycle after the read.
